main_memory: RTL and testbench
==============================

// Module: main_memory
// PURPOSE
// - Word-addressed single-port-read / single-port-write data memory for the pipelined MIPS CPU.
// - Accepts one packed 65-bit write request and one 32-bit read address per clock.
// - Returns a registered 32-bit read word; serves as instruction/data backing store.
// PARAMETERS
// - DEPTH       512  number of 32-bit words stored
// - ADDR_W      32   width of address fields (only low $clog2(DEPTH) bits index the array)
// - DATA_W      32   word width
// PORTS
// - CLOCK          in   1        system clock; all state changes on rising edge
// - RESET          in   1        synchronous, active-low reset
// - ENABLE         in   1        1 = memory operates; 0 = hold DATA, ignore writes
// - FETCH_ADDRESS  in   32       word index to read
// - EDIT_SERIAL    in   65       packed write: [64]=write enable, [63:32]=word index, [31:0]=write data
// - DATA           out  32       registered read word
// BEHAVIOUR
// - One clock domain; reset is synchronous and active-low: sampled only on rising CLOCK edge.
// - Reset (RESET==0 at edge): DATA<=0; every array word <=0; writes/reads that cycle ignored.
// - Reset dominates ENABLE and EDIT_SERIAL[64].
// - ENABLE==0 (not in reset): DATA holds previous value; array unchanged.
// - Write: at edge with RESET==1, ENABLE==1, EDIT_SERIAL[64]==1 and index<DEPTH:
//   mem[EDIT_SERIAL[63:32]] <= EDIT_SERIAL[31:0].
// - Read: at edge with RESET==1, ENABLE==1: DATA <= mem[FETCH_ADDRESS] (1-cycle latency,
//   value visible after the edge, stable for the whole following cycle).
// - Read-during-write, same index: write-first; DATA gets the new EDIT_SERIAL[31:0] that same edge.
// - Read-during-write, different index: DATA gets old contents of FETCH_ADDRESS; write proceeds.
// - Out-of-range index (>=DEPTH): write silently dropped; read returns 32'h0. No wrap-around.
// - EDIT_SERIAL[64]==0: data/address fields ignored, no array change.
// - Addresses are word indices, not byte addresses; no alignment or byte enables.
// - No X on DATA after first reset edge; DATA is 0 until first enabled read.
// STRUCTURE
// - Shared package (cpu_pkg): DATA_W, ADDR_W, MEM_DEPTH constants; typedef word_t (32b);
//   typedef mem_req_t packed struct {we; addr; wdata} matching the 65-bit EDIT_SERIAL layout.
// - One natural sub-module: main_memory_array (storage + clear-on-reset + write port);
//   top does request unpacking, range check, write-first bypass and DATA register.
// TESTING
// - Reset: RESET=0 one edge, then RESET=1, ENABLE=1, FETCH=5, no write -> DATA==0; all words read 0.
// - Write then read: edge1 EDIT={1,1,2}, FETCH=1 -> DATA==2 (write-first);
//   edge2 EDIT={1,2,3}, FETCH=1 -> DATA==2; edge3 EDIT=0, FETCH=2 -> DATA==3.
// - ENABLE=0 with EDIT={1,7,32'hDEAD_BEEF}, FETCH=7 -> DATA unchanged; re-enable, FETCH=7 -> old value (0).
// - Out of range: EDIT={1,512,32'h1234} then FETCH=512 -> DATA==0; FETCH=0 -> 0 (no wrap).
// - Mid-operation reset: write word 3 = 32'hA5A5_A5A5, assert RESET=0 one edge,
//   then FETCH=3 -> DATA==0; write during reset cycle has no effect.
// - Boundary: write index 511 = 32'hFFFF_FFFF, FETCH=511 next edge -> DATA==32'hFFFF_FFFF.

Source files
------------

// File: rtl/main_memory_pkg.sv
// -----------------------------------------------------------------------------
// main_memory_pkg
// Shared constants and types for the CPU main memory.
//   DATA_W    : word width in bits
//   ADDR_W    : width of every address field (word index, not byte address)
//   MEM_DEPTH : number of words stored
//   word_t    : one data word
//   addr_t    : one word index
//   mem_req_t : packed write request; its bit layout is the 65-bit EDIT_SERIAL
//               bus, i.e. [64]=we, [63:32]=addr, [31:0]=wdata
// -----------------------------------------------------------------------------
package main_memory_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 512;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Field order matters: the first member lands in the MSBs.
    typedef struct packed {
        logic  we;
        addr_t addr;
        word_t wdata;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/main_memory_if.sv
// -----------------------------------------------------------------------------
// main_memory_if
// Request/response bundle between a memory client and main_memory.
//   ENABLE        : 1 = memory operates, 0 = hold DATA and ignore writes
//   FETCH_ADDRESS : word index to read
//   EDIT_SERIAL   : packed write request (layout of mem_req_t)
//   DATA          : registered read word
// Modports: master = client side, slave = memory side.
// -----------------------------------------------------------------------------
interface main_memory_if
    import main_memory_pkg::*;
    ;

    logic             ENABLE;
    addr_t            FETCH_ADDRESS;
    logic [REQ_W-1:0] EDIT_SERIAL;
    word_t            DATA;

    modport master (
        output ENABLE,
        output FETCH_ADDRESS,
        output EDIT_SERIAL,
        input  DATA
    );

    modport slave (
        input  ENABLE,
        input  FETCH_ADDRESS,
        input  EDIT_SERIAL,
        output DATA
    );

endinterface

// File: rtl/main_memory_array.sv
// -----------------------------------------------------------------------------
// main_memory_array
// Word storage with one synchronous write port and one asynchronous read port.
// The whole array is cleared while rst_n is low at a rising clock edge.
//   clk     : clock
//   rst_n   : synchronous, active-low clear of every word
//   wr_en   : write strobe (caller has already qualified enable and range)
//   wr_idx  : word index written
//   wr_data : word written
//   rd_idx  : word index read
//   rd_data : current (pre-edge) contents of rd_idx
// -----------------------------------------------------------------------------
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  word_t            wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output word_t            rd_data
);

    word_t mem [DEPTH];

    // Storage is flop-based so that reset can clear every word in one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
// Word-addressed data/instruction memory for the pipelined MIPS CPU.
// One write request and one read address are accepted per clock; the read
// word is registered (1-cycle latency). Same-index read-during-write returns
// the new data (write-first). Indices >= DEPTH drop writes and read as zero.
//   CLOCK : system clock, all state changes on the rising edge
//   RESET : synchronous, active-low; clears DATA and every stored word
//   bus   : main_memory_if.slave (ENABLE, FETCH_ADDRESS, EDIT_SERIAL, DATA)
// -----------------------------------------------------------------------------
module main_memory
    import main_memory_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic         CLOCK,
    input  logic         RESET,
    main_memory_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);

    mem_req_t         req;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    word_t            array_rd;
    word_t            rd_word;
    word_t            data_q;

    assign req = mem_req_t'(bus.EDIT_SERIAL);

    // Full-width compares: upper address bits must not alias onto the array.
    assign wr_in_range = (req.addr < addr_t'(DEPTH));
    assign rd_in_range = (bus.FETCH_ADDRESS < addr_t'(DEPTH));

    assign wr_idx = req.addr[IDX_W-1:0];
    assign rd_idx = bus.FETCH_ADDRESS[IDX_W-1:0];

    // A write that will actually land in the array this edge.
    assign wr_hit = bus.ENABLE && req.we && wr_in_range;

    main_memory_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .wr_en   (wr_hit),
        .wr_idx  (wr_idx),
        .wr_data (req.wdata),
        .rd_idx  (rd_idx),
        .rd_data (array_rd)
    );

    // Write-first bypass: the array still holds the old word this cycle,
    // so a same-index write is forwarded straight into the read register.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_hit && (wr_idx == rd_idx)) begin
                rd_word = req.wdata;
            end else begin
                rd_word = array_rd;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            data_q <= '0;
        end else if (bus.ENABLE) begin
            data_q <= rd_word;
        end
    end

    assign bus.DATA = data_q;

endmodule

// File: tb/tb_main_memory.sv
// -----------------------------------------------------------------------------
// tb_main_memory
// Directed self-checking bench for main_memory.
// -----------------------------------------------------------------------------
module tb_main_memory;
    import main_memory_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    main_memory_if bus ();

    main_memory dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, take one rising edge, settle 1 time unit.
    task automatic apply(input logic rst_v, input logic en, input logic we,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] fetch);
        rst_n             = rst_v;
        bus.ENABLE        = en;
        bus.EDIT_SERIAL   = {we, waddr, wdata};
        bus.FETCH_ADDRESS = fetch;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset must dominate a write request presented in the same cycle.
        apply(1'b0, 1'b1, 1'b1, 32'd5, 32'h0000_0ABC, 32'd5);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd5);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_fetch5 got=%h exp=%h", bus.DATA, 32'h0);
        end
        for (int i = 0; i < 512; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, i);
            vectors++;
            if (bus.DATA !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_clear idx=%0d got=%h exp=%h", i, bus.DATA, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        apply(1'b1, 1'b1, 1'b1, 32'd1, 32'd2, 32'd1);
        vectors++;
        if (bus.DATA !== 32'd2) begin
            miscompares++;
            $display("FAIL wr_first_same_idx got=%h exp=%h", bus.DATA, 32'd2);
        end
        apply(1'b1, 1'b1, 1'b1, 32'd2, 32'd3, 32'd1);
        vectors++;
        if (bus.DATA !== 32'd2) begin
            miscompares++;
            $display("FAIL rd_during_wr_other got=%h exp=%h", bus.DATA, 32'd2);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd2);
        vectors++;
        if (bus.DATA !== 32'd3) begin
            miscompares++;
            $display("FAIL read_back_2 got=%h exp=%h", bus.DATA, 32'd3);
        end
    endtask

    task automatic test_enable();
        // DATA currently 3 from the previous task.
        apply(1'b1, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF, 32'd7);
        vectors++;
        if (bus.DATA !== 32'd3) begin
            miscompares++;
            $display("FAIL disabled_hold got=%h exp=%h", bus.DATA, 32'd3);
        end
        apply(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd1);
        vectors++;
        if (bus.DATA !== 32'd3) begin
            miscompares++;
            $display("FAIL disabled_hold2 got=%h exp=%h", bus.DATA, 32'd3);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd7);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL disabled_no_write got=%h exp=%h", bus.DATA, 32'h0);
        end
    endtask

    task automatic test_out_of_range();
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd2);
        vectors++;
        if (bus.DATA !== 32'd3) begin
            miscompares++;
            $display("FAIL oor_preload got=%h exp=%h", bus.DATA, 32'd3);
        end
        apply(1'b1, 1'b1, 1'b1, 32'd512, 32'h0000_1234, 32'd512);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_read512 got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_no_wrap got=%h exp=%h", bus.DATA, 32'h0);
        end
        // High address bits set with a low part that would alias word 1.
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'h8000_0001);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL oor_high_bits got=%h exp=%h", bus.DATA, 32'h0);
        end
    endtask

    task automatic test_mid_reset();
        apply(1'b1, 1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5, 32'd3);
        vectors++;
        if (bus.DATA !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("FAIL mid_write3 got=%h exp=%h", bus.DATA, 32'hA5A5_A5A5);
        end
        apply(1'b0, 1'b1, 1'b1, 32'd4, 32'h0000_0055, 32'd3);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_data got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd3);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_word3 got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd4);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_word4 got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset_word1 got=%h exp=%h", bus.DATA, 32'h0);
        end
    endtask

    task automatic test_boundary();
        apply(1'b1, 1'b1, 1'b1, 32'd511, 32'hFFFF_FFFF, 32'd0);
        vectors++;
        if (bus.DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL bnd_write511 got=%h exp=%h", bus.DATA, 32'h0);
        end
        apply(1'b1, 1'b1, 1'b1, 32'd10, 32'h0000_0077, 32'd511);
        vectors++;
        if (bus.DATA !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL bnd_read511 got=%h exp=%h", bus.DATA, 32'hFFFF_FFFF);
        end
        apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd10);
        vectors++;
        if (bus.DATA !== 32'h0000_0077) begin
            miscompares++;
            $display("FAIL bnd_read10 got=%h exp=%h", bus.DATA, 32'h0000_0077);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 1'b1, 32'd100 + i, 32'h1000_0000 + i * 3, 32'd511);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd100 + i);
            exp = 32'h1000_0000 + i * 3;
            vectors++;
            if (bus.DATA !== exp) begin
                miscompares++;
                $display("FAIL b2b_read idx=%0d got=%h exp=%h", 100 + i, bus.DATA, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n             = 1'b0;
        bus.ENABLE        = 1'b0;
        bus.EDIT_SERIAL   = '0;
        bus.FETCH_ADDRESS = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_enable();
        test_out_of_range();
        test_mid_reset();
        test_boundary();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
